btn_conditioner: RTL

Front-end input stage that sits directly upstream of the pong game top and feeds its btnU/btnD/btnL/btnR controls. For each raw push-button it synchronises, debounces and edge-detects the input. It then produces level, press, release and auto-repeat "action" strobes in the system clock domain, so paddle logic sees one clean event per press plus a steady repeat while a button is held.

---
 rtl/btn_conditioner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button input conditioning ahead of the pong game controls.
// Each raw push-button is synchronised (2 flops), debounced, edge-detected and
// fed to an auto-repeat FSM. Every button channel is fully independent.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   en_i           strobe enable; debouncing keeps running when low, strobes are suppressed
//   btn_raw_i      raw asynchronous buttons, active-high (bit 0=U, 1=D, 2=L, 3=R)
//   btn_level_o    debounced button state
//   btn_press_o    1-cycle strobe in the first cycle btn_level_o reads 1
//   btn_release_o  1-cycle strobe in the first cycle btn_level_o reads 0
//   btn_act_o      1-cycle action strobe: initial press plus auto-repeats
module btn_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic [N_BTN-1:0] btn_act_o
);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } state_e;

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  // Two-flop synchroniser for all buttons; sync_q is the usable copy.
  logic [N_BTN-1:0] meta_q;
  logic [N_BTN-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_raw_i;
      sync_q <= meta_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             level_q, level_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             act_q, act_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    state_e           state_q, state_d;
    logic             rise, fall;

    // Debounce: count consecutive cycles the synchronised input disagrees with
    // the accepted level; any agreement (glitch back) restarts the count.
    always_comb begin
      level_d = level_q;
      dcnt_d  = dcnt_q;
      if (sync_q[i] == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DebLast) begin
        level_d = sync_q[i];
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + CntOne;
      end
    end

    // Edges are taken on the next-state level so the strobes line up with the
    // first cycle the registered level shows its new value.
    assign rise      = level_d & ~level_q;
    assign fall      = ~level_d & level_q;
    assign press_d   = rise & en_i;
    assign release_d = fall & en_i;

    // Repeat FSM. Only a genuine rising edge with en_i high leaves StIdle, so
    // enabling mid-hold never produces a retroactive action.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      act_d   = 1'b0;
      if (!level_d || !en_i) begin
        state_d = StIdle;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (rise) begin
              act_d   = 1'b1;
              rcnt_d  = '0;
              state_d = StHold;
            end
          end
          StHold: begin
            if (rcnt_q == DelayLast) begin
              act_d   = 1'b1;
              rcnt_d  = '0;
              state_d = StRepeat;
            end else begin
              rcnt_d = rcnt_q + CntOne;
            end
          end
          StRepeat: begin
            if (rcnt_q == RateLast) begin
              act_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + CntOne;
            end
          end
          default: begin
            state_d = StIdle;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        level_q   <= 1'b0;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        act_q     <= 1'b0;
        rcnt_q    <= '0;
        state_q   <= StIdle;
      end else begin
        level_q   <= level_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        act_q     <= act_d;
        rcnt_q    <= rcnt_d;
        state_q   <= state_d;
      end
    end

    assign btn_level_o[i]   = level_q;
    assign btn_press_o[i]   = press_q;
    assign btn_release_o[i] = release_q;
    assign btn_act_o[i]     = act_q;
  end

endmodule
